// File: rtl/ddr2_tg_pkg.sv
// Shared definitions for the DDR2 local-interface traffic generator.
//   tg_state_t   : sequencer states
//   pattern_word : deterministic beat pattern for a beat address
package ddr2_tg_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        WRITE     = 3'd2,
        READ      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } tg_state_t;

    // Widest data bus the pattern generator covers; callers slice DATA_W bits.
    localparam int PAT_MAX_W = 1024;

    // Lane i of the beat at address a = {i[2:0], 4'b0000, a[24:0]}.
    function automatic logic [PAT_MAX_W-1:0] pattern_word(input logic [24:0] addr);
        logic [PAT_MAX_W-1:0] w;
        w = '0;
        for (int i = 0; i < PAT_MAX_W / 32; i++) begin
            w[i*32 +: 32] = {i[2:0], 4'b0000, addr};
        end
        return w;
    endfunction

endpackage

// File: rtl/ddr2_local_traffic_gen_if.sv
// Controller local (Avalon-style) user interface.
//   master : traffic generator side (drives requests, receives read data)
//   slave  : controller side
interface ddr2_local_traffic_gen_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 256,
    parameter int SIZE_W = 3
);
    logic                  local_init_done;
    logic                  local_ready;
    logic [ADDR_W-1:0]     local_address;
    logic                  local_write_req;
    logic                  local_read_req;
    logic                  local_burstbegin;
    logic [SIZE_W-1:0]     local_size;
    logic [DATA_W/8-1:0]   local_be;
    logic [DATA_W-1:0]     local_wdata;
    logic [DATA_W-1:0]     local_rdata;
    logic                  local_rdata_valid;

    modport master (
        input  local_init_done, local_ready, local_rdata, local_rdata_valid,
        output local_address, local_write_req, local_read_req, local_burstbegin,
               local_size, local_be, local_wdata
    );

    modport slave (
        output local_init_done, local_ready, local_rdata, local_rdata_valid,
        input  local_address, local_write_req, local_read_req, local_burstbegin,
               local_size, local_be, local_wdata
    );
endinterface

// File: rtl/ddr2_tg_checker.sv
// Read-side accounting and compare for the traffic generator.
//   load           : accepted start; reloads expected address, beat budget, clears errors
//   enable         : read data is meaningful (READ/DRAIN)
//   rdata_valid/rdata : returning read beats
//   read_accept    : a read burst was accepted this cycle
//   inflight_full  : read bursts in flight == MAX_OUTSTANDING
//   all_checked    : every expected beat has been compared
//   err_count / first_err_addr : mismatch statistics
module ddr2_tg_checker
    import ddr2_tg_pkg::*;
#(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 256,
    parameter int SIZE_W          = 3,
    parameter int BURST_LEN       = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [15:0]       cfg_num_bursts,
    input  logic              enable,
    input  logic              rdata_valid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              read_accept,
    output logic              inflight_full,
    output logic              all_checked,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam int                BEATS_W   = 16 + SIZE_W;
    localparam logic [SIZE_W-1:0] LAST_BEAT = SIZE_W'(BURST_LEN - 1);

    logic                 beat_in;
    logic                 burst_ret;
    logic                 vld_q;
    logic                 mismatch;
    logic [SIZE_W-1:0]    rx_beat;
    logic [7:0]           inflight;
    logic [ADDR_W-1:0]    exp_addr;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [BEATS_W-1:0]   beats_left;
    logic [PAT_MAX_W-1:0] pat_full;
    logic                 unused_pat;

    assign beat_in       = rdata_valid && enable;
    assign burst_ret     = beat_in && (rx_beat == LAST_BEAT);
    assign inflight_full = (inflight == 8'(MAX_OUTSTANDING));
    assign all_checked   = (beats_left == '0);

    assign pat_full   = pattern_word(25'(addr_q));
    // Lanes above DATA_W are never compared.
    assign unused_pat = ^pat_full;
    assign mismatch   = vld_q && (rdata_q != pat_full[DATA_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_beat  <= '0;
            inflight <= '0;
        end else if (load) begin
            rx_beat  <= '0;
            inflight <= '0;
        end else begin
            if (beat_in) begin
                rx_beat <= burst_ret ? '0 : rx_beat + 1'b1;
            end
            // Accept and burst return in the same cycle cancel out.
            if (read_accept && !burst_ret) begin
                inflight <= inflight + 8'd1;
            end else if (!read_accept && burst_ret) begin
                inflight <= inflight - 8'd1;
            end
        end
    end

    // Capture stage: the compare runs one cycle after the beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            exp_addr <= '0;
        end else if (load) begin
            vld_q    <= 1'b0;
            exp_addr <= cfg_start_addr;
        end else begin
            vld_q <= beat_in;
            if (beat_in) begin
                rdata_q  <= rdata;
                addr_q   <= exp_addr;
                exp_addr <= exp_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
            beats_left     <= '0;
        end else if (load) begin
            err_count      <= '0;
            first_err_addr <= '0;
            beats_left     <= BEATS_W'(cfg_num_bursts) * BEATS_W'(BURST_LEN);
        end else begin
            if (vld_q && beats_left != '0) begin
                beats_left <= beats_left - 1'b1;
            end
            if (mismatch) begin
                if (err_count == '0) begin
                    first_err_addr <= addr_q;
                end
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr2_local_traffic_gen.sv
// DDR2 local-interface traffic generator: writes a pattern over a burst
// range, reads it back in order and reports pass/fail plus an error count.
//   phy_clk, reset_phy_clk_n : clock / async active-low reset
//   start, cfg_*             : test launch and range configuration
//   busy, done, pass, err_count, first_err_addr : status
//   local_bus                : master side of the controller local interface
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_INIT | test armed, waiting for controller calibration
// WRITE     | issuing write beats back to back
// READ      | issuing read bursts, limited by in-flight count
// DRAIN     | all reads issued, waiting for the last beats to compare
// DONE      | result valid; start relaunches
module ddr2_local_traffic_gen
    import ddr2_tg_pkg::*;
#(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 256,
    parameter int SIZE_W          = 3,
    parameter int BURST_LEN       = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              phy_clk,
    input  logic              reset_phy_clk_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [15:0]       cfg_num_bursts,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    ddr2_local_traffic_gen_if.master local_bus
);
    localparam logic [SIZE_W-1:0] LAST_BEAT  = SIZE_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);

    tg_state_t            state;
    tg_state_t            state_nxt;
    logic [ADDR_W-1:0]    start_addr_q;
    logic [ADDR_W-1:0]    burst_addr;
    logic [15:0]          num_bursts_q;
    logic [15:0]          burst_cnt;
    logic [SIZE_W-1:0]    beat;
    logic                 start_ok;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 last_burst;
    logic                 last_beat;
    logic                 chk_enable;
    logic                 inflight_full;
    logic                 all_checked;
    logic [PAT_MAX_W-1:0] pat_full;
    logic                 unused_pat;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign wr_accept  = local_bus.local_write_req && local_bus.local_ready;
    assign rd_accept  = local_bus.local_read_req && local_bus.local_ready;
    assign last_burst = (burst_cnt == num_bursts_q - 16'd1);
    assign last_beat  = (beat == LAST_BEAT);
    assign chk_enable = (state == READ) || (state == DRAIN);

    assign pat_full   = pattern_word(25'(burst_addr + ADDR_W'(beat)));
    assign unused_pat = ^pat_full;

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (cfg_num_bursts == 16'd0) ? DONE : WAIT_INIT;
            WAIT_INIT:  if (local_bus.local_init_done) state_nxt = WRITE;
            WRITE:      if (wr_accept && last_beat && last_burst) state_nxt = READ;
            READ:       if (rd_accept && last_burst) state_nxt = DRAIN;
            DRAIN:      if (all_checked) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        local_bus.local_write_req  = 1'b0;
        local_bus.local_read_req   = 1'b0;
        local_bus.local_burstbegin = 1'b0;
        local_bus.local_address    = '0;
        local_bus.local_wdata      = '0;
        local_bus.local_size       = SIZE_W'(BURST_LEN);
        local_bus.local_be         = '1;
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            WAIT_INIT, DRAIN: busy = 1'b1;
            WRITE: begin
                busy                       = 1'b1;
                local_bus.local_write_req  = 1'b1;
                local_bus.local_burstbegin = (beat == '0);
                local_bus.local_address    = burst_addr;
                local_bus.local_wdata      = pat_full[DATA_W-1:0];
            end
            READ: begin
                busy                       = 1'b1;
                local_bus.local_read_req   = !inflight_full;
                local_bus.local_burstbegin = !inflight_full;
                local_bus.local_address    = burst_addr;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == 16'd0);
            end
            default: ;
        endcase
    end

    // Request address/beat counters only move on acceptance, which keeps
    // address and data stable across stalls. The burst pointer rewinds to
    // the start address for the read pass.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            start_addr_q <= '0;
            num_bursts_q <= '0;
            burst_addr   <= '0;
            burst_cnt    <= '0;
            beat         <= '0;
        end else if (start_ok) begin
            start_addr_q <= cfg_start_addr;
            num_bursts_q <= cfg_num_bursts;
            burst_addr   <= cfg_start_addr;
            burst_cnt    <= '0;
            beat         <= '0;
        end else if (wr_accept) begin
            if (last_beat) begin
                beat <= '0;
                if (last_burst) begin
                    burst_cnt  <= '0;
                    burst_addr <= start_addr_q;
                end else begin
                    burst_cnt  <= burst_cnt + 16'd1;
                    burst_addr <= burst_addr + BURST_STEP;
                end
            end else begin
                beat <= beat + 1'b1;
            end
        end else if (rd_accept) begin
            burst_cnt  <= burst_cnt + 16'd1;
            burst_addr <= burst_addr + BURST_STEP;
        end
    end

    ddr2_tg_checker #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .SIZE_W          (SIZE_W),
        .BURST_LEN       (BURST_LEN),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_checker (
        .clk            (phy_clk),
        .rst_n          (reset_phy_clk_n),
        .load           (start_ok),
        .cfg_start_addr (cfg_start_addr),
        .cfg_num_bursts (cfg_num_bursts),
        .enable         (chk_enable),
        .rdata_valid    (local_bus.local_rdata_valid),
        .rdata          (local_bus.local_rdata),
        .read_accept    (rd_accept),
        .inflight_full  (inflight_full),
        .all_checked    (all_checked),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: doc/ddr2_local_traffic_gen.md
Name: ddr2_local_traffic_gen

Overview:
- Master on the controller's local (Avalon-style) user interface; the initiator side of the local_* port set exported by the DDR2 controller+PHY top.
- Writes a deterministic pattern over a configured burst range, then reads it back in order, compares every beat, and reports pass/fail and an error count.
- Used for board bring-up and regression, between a host/CSR block and the DDR2 controller top.

Parameters:
- ADDR_W, 25, local_address width (local words).
- DATA_W, 256, local_wdata/local_rdata width; must be a multiple of 32.
- SIZE_W, 3, local_size width.
- BURST_LEN, 2, beats per burst; 1..2^SIZE_W-1.
- MAX_OUTSTANDING, 8, maximum read bursts in flight; 1..255.

Ports:
- phy_clk  in  1  Clock, controller phy_clk domain.
- reset_phy_clk_n  in  1  Async active-low reset.
- start  in  1  One-cycle pulse; begins a test when idle.
- cfg_start_addr  in  ADDR_W  First burst address; sampled on an accepted start.
- cfg_num_bursts  in  16  Number of bursts; sampled on an accepted start.
- busy  out  1  High from an accepted start until done.
- done  out  1  Level; set when the test completes, cleared by the next accepted start.
- pass  out  1  Valid while done; 1 when err_count == 0.
- err_count  out  16  Mismatching beats; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  Beat address of the first mismatch.
- local_init_done  in  1  Controller calibration complete.
- local_ready  in  1  Controller accepts the current request.
- local_address  out  ADDR_W  Burst address.
- local_write_req, local_read_req, local_burstbegin  out  1 each  Request strobes.
- local_size  out  SIZE_W  Constant BURST_LEN.
- local_be  out  DATA_W/8  All ones.
- local_wdata  out  DATA_W  Write beat data.
- local_rdata  in  DATA_W  Read beat data.
- local_rdata_valid  in  1  Read beat strobe.

Behaviour:
- Reset values: all outputs 0, except local_size = BURST_LEN and local_be = all ones. The FSM resets to IDLE.
- Reset asserted mid-test aborts immediately: requests drop, counters clear, and no done is produced.
- Burst k address = cfg_start_addr + k*BURST_LEN, modulo 2^ADDR_W (wraps silently). Beat j of burst k has beat address = burst address + j.
- Pattern: for beat address a, 32-bit lane i = {i[2:0], 4'b0000, a zero-extended/truncated to 25 bits}.
- Handshake: a request is accepted in any cycle where a req is high and local_ready is high. Address, data and strobes hold stable until acceptance.
- Each write beat is a separate accepted write_req. local_burstbegin is high only on beat 0, together with local_address.
- A read is a single accepted read_req with burstbegin, returning BURST_LEN beats.
- States:
  - IDLE: accepted start with cfg_num_bursts == 0 -> DONE with pass = 1. Other accepted start -> WAIT_INIT. start while busy is ignored.
  - WAIT_INIT: wait for local_init_done -> WRITE.
  - WRITE: issue all bursts back to back, no idle gaps when local_ready is high. After the last beat is accepted -> READ, no gap cycle.
  - READ: issue read bursts in order while in-flight bursts < MAX_OUTSTANDING. After the last read is accepted -> DRAIN.
  - DRAIN: wait until all expected beats have returned -> DONE.
  - DONE: busy = 0, done = 1; an accepted start restarts from WAIT_INIT.
- In-flight counter: +1 on an accepted read, -1 on the last beat of a returning burst; both in the same cycle leaves it unchanged. A read is never issued when the counter equals MAX_OUTSTANDING.
- Compare: beats are checked in order against an expected beat-address counter, one cycle after local_rdata_valid (registered). On a mismatch, err_count increments (saturating); first_err_addr is captured only on the first error.
- local_rdata_valid outside READ/DRAIN is ignored.
- done rises one cycle after the final comparison completes.

Decomposition:
- Shared package ddr2_tg_pkg: state enum (IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE) and the pattern function pattern_word(addr) -> DATA_W.
- One sub-module, ddr2_tg_checker: expected-address counter, registered compare, err_count, first_err_addr and beat/in-flight accounting. The top holds the FSM and request generation.

Test Plan:
- Ideal memory model, local_ready = 1, start_addr = 0, num_bursts = 4 -> 8 write beats on consecutive cycles, 4 reads issued, done = 1, pass = 1, err_count = 0.
- Model flips bit 0 of the beat at address 5 -> err_count = 1, first_err_addr = 5, pass = 0.
- local_ready toggled randomly, read latency 40 cycles, MAX_OUTSTANDING = 2 -> never more than 2 reads in flight, requests held stable while stalled, pass = 1.
- start_addr = 2^25 - 2, num_bursts = 2 -> burst addresses 0x1FFFFFE then 0x0000000, pass = 1.
- num_bursts = 0 -> done the cycle after start, pass = 1, no local requests. Also: local_init_done low for 100 cycles -> no requests during that time.
- Reset asserted during DRAIN -> all outputs return to reset values; a new start afterwards completes with pass = 1.
